// File: rtl/spi_frame_tx.sv
// SPI mode-0 slave transmitter: shifts a parallel status frame out on MISO, MSB first.
// SCLK and CS are oversampled in the clk domain.
module spi_frame_tx #(
   parameter int FRAME_BITS  = 408,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   input  logic [FRAME_BITS-1:0] data_in,
   input  logic                  LOAD,
   input  logic                  CS,
   input  logic                  SCLK,
   output logic                  MISO,
   output logic                  MISO_OE,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ABORT
);

   localparam int CNT_W = $clog2(FRAME_BITS + 2);
   localparam int SET_W = $clog2(SYNC_STAGES + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
   localparam logic [SET_W-1:0] SETTLED  = SET_W'(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      WAIT_HIGH,
      IDLE,
      SHIFT
   } state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  sclk_sync_p0;
   logic [SYNC_STAGES-1:0]  cs_sync_p0;
   logic                    sclk_hist_p1;
   logic                    cs_hist_p1;
   logic [FRAME_BITS-1:0]   shadow;
   logic [FRAME_BITS-1:0]   shift_reg;
   logic [CNT_W-1:0]        bit_cnt;
   logic [SET_W-1:0]        settle_cnt;

   logic sclk_s;
   logic cs_s;
   logic sclk_rise;
   logic sclk_fall;
   logic cs_rise;
   logic cs_fall;

   // Synchroniser chains plus one history flop each for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_p0 <= '0;
         cs_sync_p0   <= '1;
         sclk_hist_p1 <= 1'b0;
         cs_hist_p1   <= 1'b1;
      end else if (clk_en) begin
         sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], SCLK};
         cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], CS};
         sclk_hist_p1 <= sclk_sync_p0[SYNC_STAGES-1];
         cs_hist_p1   <= cs_sync_p0[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
   assign cs_s      = cs_sync_p0[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_hist_p1;
   assign sclk_fall = ~sclk_s & sclk_hist_p1;
   assign cs_rise   = cs_s & ~cs_hist_p1;
   assign cs_fall   = ~cs_s & cs_hist_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
      end else if (clk_en && LOAD) begin
         shadow <= data_in;
      end
   end

   // Control FSM; settle_cnt keeps WAIT_HIGH until the synchronisers hold real pin values
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT_HIGH;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         settle_cnt <= '0;
         MISO       <= 1'b0;
         DONE       <= 1'b0;
         ABORT      <= 1'b0;
      end else if (clk_en) begin
         DONE  <= 1'b0;
         ABORT <= 1'b0;
         case (state)
            WAIT_HIGH: begin
               if (settle_cnt != SETTLED) begin
                  settle_cnt <= settle_cnt + 1'b1;
               end else if (cs_s) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (cs_fall) begin
                  shift_reg <= shadow;
                  bit_cnt   <= '0;
                  MISO      <= shadow[FRAME_BITS-1];
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               // A CS rise takes priority over any SCLK edge in the same cycle
               if (cs_rise) begin
                  DONE  <= (bit_cnt == CNT_FULL);
                  ABORT <= (bit_cnt != CNT_FULL);
                  MISO  <= 1'b0;
                  state <= IDLE;
               end else if (sclk_rise) begin
                  if (bit_cnt != CNT_SAT) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (sclk_fall && (bit_cnt != '0)) begin
                  shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                  MISO      <= shift_reg[FRAME_BITS-2];
               end
            end
            default: begin
               state <= WAIT_HIGH;
            end
         endcase
      end
   end

   assign BUSY    = (state == SHIFT);
   assign MISO_OE = (state == SHIFT) && !cs_s;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed testbench for spi_frame_tx: full frames, back-to-back reuse, abort,
// overrun, CS held low through reset, mid-frame reset and clock-enable gating.
module tb_spi_frame_tx;

   localparam int FB = 408;
   localparam int SS = 2;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          clk_en  = 1'b1;
   logic          LOAD    = 1'b0;
   logic          CS      = 1'b1;
   logic          SCLK    = 1'b0;
   logic [FB-1:0] data_in = '0;
   logic          MISO;
   logic          MISO_OE;
   logic          BUSY;
   logic          DONE;
   logic          ABORT;

   logic          en_toggle = 1'b0;
   int            n_checks  = 0;
   int            n_fail    = 0;
   int            hp        = 6;
   int            done_en   = 0;
   int            abort_en  = 0;
   int            busy_low;
   int            oe_low;
   int            d0;
   int            a0;
   logic [FB-1:0] cap_frame;
   logic [1:0]    cap_tail;
   logic [FB-1:0] vec1;
   logic [FB-1:0] a5;
   logic [FB-1:0] ones;
   logic [FB-1:0] part;

   spi_frame_tx #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .data_in (data_in),
      .LOAD    (LOAD),
      .CS      (CS),
      .SCLK    (SCLK),
      .MISO    (MISO),
      .MISO_OE (MISO_OE),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .ABORT   (ABORT)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 clk_en = en_toggle ? ~clk_en : 1'b1;
   end

   // Count DONE/ABORT only in cycles whose next edge is enabled
   always @(negedge clk) begin
      if (DONE && clk_en)  done_en++;
      if (ABORT && clk_en) abort_en++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input logic [FB-1:0] v);
      data_in = v;
      LOAD = 1'b1;
      cyc(1);
      LOAD = 1'b0;
      cyc(1);
   endtask

   task automatic run_frame(input int nclk, input int load_at, input logic [FB-1:0] load_val);
      busy_low  = 0;
      oe_low    = 0;
      cap_frame = '0;
      cap_tail  = '0;
      CS = 1'b0;
      cyc(hp);
      for (int i = 0; i < nclk; i++) begin
         if (i < FB) cap_frame[FB-1-i] = MISO;
         else if (i - FB < 2) cap_tail[i-FB] = MISO;
         if (BUSY !== 1'b1) busy_low++;
         if (MISO_OE !== 1'b1) oe_low++;
         SCLK = 1'b1;
         cyc(hp);
         SCLK = 1'b0;
         if (i == load_at) begin
            data_in = load_val;
            LOAD = 1'b1;
            cyc(1);
            LOAD = 1'b0;
            cyc(hp - 1);
         end else begin
            cyc(hp);
         end
      end
      CS = 1'b1;
      cyc(3 * hp);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(4);
      rst = 1'b0;
      cyc(1);
      n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset MISO: got %b expected 0", MISO); end
      n_checks++; if (MISO_OE !== 1'b0) begin n_fail++; $display("FAIL reset MISO_OE: got %b expected 0", MISO_OE); end
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset BUSY: got %b expected 0", BUSY); end
      n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset DONE: got %b expected 0", DONE); end
      n_checks++; if (ABORT !== 1'b0) begin n_fail++; $display("FAIL reset ABORT: got %b expected 0", ABORT); end
      cyc(hp);
   endtask

   task automatic test_full_frame();
      load_frame(vec1);
      d0 = done_en; a0 = abort_en;
      run_frame(FB, -1, '0);
      n_checks++; if (cap_frame !== vec1) begin n_fail++; $display("FAIL full_frame data: got %h expected %h", cap_frame, vec1); end
      n_checks++; if (done_en - d0 !== 1) begin n_fail++; $display("FAIL full_frame DONE pulses: got %0d expected 1", done_en - d0); end
      n_checks++; if (abort_en - a0 !== 0) begin n_fail++; $display("FAIL full_frame ABORT pulses: got %0d expected 0", abort_en - a0); end
      n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL full_frame BUSY low samples: got %0d expected 0", busy_low); end
      n_checks++; if (oe_low !== 0) begin n_fail++; $display("FAIL full_frame MISO_OE low samples: got %0d expected 0", oe_low); end
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL full_frame BUSY after: got %b expected 0", BUSY); end
      n_checks++; if (MISO_OE !== 1'b0) begin n_fail++; $display("FAIL full_frame MISO_OE after: got %b expected 0", MISO_OE); end
      n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL full_frame MISO after: got %b expected 0", MISO); end
   endtask

   task automatic test_back_to_back();
      load_frame(a5);
      run_frame(FB, -1, '0);
      n_checks++; if (cap_frame !== a5) begin n_fail++; $display("FAIL b2b frame1: got %h expected %h", cap_frame, a5); end
      d0 = done_en;
      run_frame(FB, 150, ones);
      n_checks++; if (cap_frame !== a5) begin n_fail++; $display("FAIL b2b frame2: got %h expected %h", cap_frame, a5); end
      n_checks++; if (done_en - d0 !== 1) begin n_fail++; $display("FAIL b2b frame2 DONE pulses: got %0d expected 1", done_en - d0); end
      run_frame(FB, -1, '0);
      n_checks++; if (cap_frame !== ones) begin n_fail++; $display("FAIL b2b frame3: got %h expected %h", cap_frame, ones); end
   endtask

   task automatic test_abort();
      d0 = done_en; a0 = abort_en;
      run_frame(200, -1, '0);
      n_checks++; if (cap_frame !== part) begin n_fail++; $display("FAIL abort data: got %h expected %h", cap_frame, part); end
      n_checks++; if (abort_en - a0 !== 1) begin n_fail++; $display("FAIL abort ABORT pulses: got %0d expected 1", abort_en - a0); end
      n_checks++; if (done_en - d0 !== 0) begin n_fail++; $display("FAIL abort DONE pulses: got %0d expected 0", done_en - d0); end
      n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL abort MISO: got %b expected 0", MISO); end
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL abort BUSY: got %b expected 0", BUSY); end
      load_frame(vec1);
      d0 = done_en;
      run_frame(FB, -1, '0);
      n_checks++; if (cap_frame !== vec1) begin n_fail++; $display("FAIL abort refill data: got %h expected %h", cap_frame, vec1); end
      n_checks++; if (done_en - d0 !== 1) begin n_fail++; $display("FAIL abort refill DONE pulses: got %0d expected 1", done_en - d0); end
   endtask

   task automatic test_overrun();
      load_frame(a5);
      d0 = done_en; a0 = abort_en;
      run_frame(FB + 2, -1, '0);
      n_checks++; if (cap_frame !== a5) begin n_fail++; $display("FAIL overrun data: got %h expected %h", cap_frame, a5); end
      n_checks++; if (cap_tail !== 2'b00) begin n_fail++; $display("FAIL overrun tail bits: got %b expected 00", cap_tail); end
      n_checks++; if (abort_en - a0 !== 1) begin n_fail++; $display("FAIL overrun ABORT pulses: got %0d expected 1", abort_en - a0); end
      n_checks++; if (done_en - d0 !== 0) begin n_fail++; $display("FAIL overrun DONE pulses: got %0d expected 0", done_en - d0); end
   endtask

   task automatic test_cs_low_reset();
      CS  = 1'b0;
      rst = 1'b1;
      cyc(4);
      rst = 1'b0;
      cyc(hp);
      busy_low = 0;
      oe_low   = 0;
      for (int i = 0; i < 16; i++) begin
         if (MISO_OE !== 1'b0) oe_low++;
         if (BUSY !== 1'b0) busy_low++;
         SCLK = 1'b1;
         cyc(hp);
         SCLK = 1'b0;
         cyc(hp);
      end
      n_checks++; if (oe_low !== 0) begin n_fail++; $display("FAIL cs_low_reset MISO_OE high samples: got %0d expected 0", oe_low); end
      n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL cs_low_reset BUSY high samples: got %0d expected 0", busy_low); end
      CS = 1'b1;
      cyc(2 * hp);
      load_frame(vec1);
      d0 = done_en;
      run_frame(FB, -1, '0);
      n_checks++; if (cap_frame !== vec1) begin n_fail++; $display("FAIL cs_low_reset frame: got %h expected %h", cap_frame, vec1); end
      n_checks++; if (done_en - d0 !== 1) begin n_fail++; $display("FAIL cs_low_reset DONE pulses: got %0d expected 1", done_en - d0); end
   endtask

   task automatic test_rst_mid_frame();
      load_frame(vec1);
      d0 = done_en; a0 = abort_en;
      CS = 1'b0;
      cyc(hp);
      for (int i = 0; i < 100; i++) begin
         SCLK = 1'b1;
         cyc(hp);
         SCLK = 1'b0;
         cyc(hp);
      end
      rst = 1'b1;
      cyc(1);
      n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL rst_mid MISO: got %b expected 0", MISO); end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         SCLK = 1'b1;
         cyc(hp);
         SCLK = 1'b0;
         cyc(hp);
      end
      CS = 1'b1;
      cyc(3 * hp);
      n_checks++; if (done_en - d0 !== 0) begin n_fail++; $display("FAIL rst_mid DONE pulses: got %0d expected 0", done_en - d0); end
      n_checks++; if (abort_en - a0 !== 0) begin n_fail++; $display("FAIL rst_mid ABORT pulses: got %0d expected 0", abort_en - a0); end
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_mid BUSY: got %b expected 0", BUSY); end
   endtask

   task automatic test_clk_en();
      load_frame(vec1);
      d0 = done_en; a0 = abort_en;
      en_toggle = 1'b1;
      hp = 12;
      run_frame(FB, -1, '0);
      en_toggle = 1'b0;
      hp = 6;
      cyc(2);
      n_checks++; if (cap_frame !== vec1) begin n_fail++; $display("FAIL clk_en data: got %h expected %h", cap_frame, vec1); end
      n_checks++; if (done_en - d0 !== 1) begin n_fail++; $display("FAIL clk_en DONE enabled cycles: got %0d expected 1", done_en - d0); end
      n_checks++; if (abort_en - a0 !== 0) begin n_fail++; $display("FAIL clk_en ABORT pulses: got %0d expected 0", abort_en - a0); end
      n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL clk_en BUSY low samples: got %0d expected 0", busy_low); end
   endtask

   initial begin
      vec1 = {64'h80000000000000F1, 48'h1, 48'h2, 32'h3, 64'h4, 16'h1, 8'h0,
              32'h5, 32'h6, 32'h7, 32'h8};
      a5   = {51{8'hA5}};
      ones = '1;
      part = {{200{1'b1}}, {208{1'b0}}};
      test_reset();
      test_full_frame();
      test_back_to_back();
      test_abort();
      test_overrun();
      test_cs_low_reset();
      test_rst_mid_frame();
      test_clk_en();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_frame_tx.md
# spi_frame_tx

SPI slave transmitter that returns one fixed-length frame from FPGA to MCU, MSB first on MISO. It is the return-direction counterpart of the 51-byte MCU→FPGA SPI frame receiver. Fabric logic loads a parallel status frame (time, frequency, pulse counters, ...) into a shadow register. The block shifts that frame out when the MCU DMA asserts CS and clocks SCLK. SCLK and CS are oversampled in the `clk` domain, so there is only one clock.

## Interface
- FRAME_BITS, 408: frame length in bits (51 bytes); sets shift register and counter widths.
- SYNC_STAGES, 2: synchroniser depth for SCLK and CS (≥2).

- clk  in  1  system clock (48 MHz nominal)
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  when 0, all registers (synchronisers included) hold
- data_in  in  FRAME_BITS  parallel frame; bit FRAME_BITS-1 is transmitted first
- LOAD  in  1  one-cycle strobe; copies data_in into shadow register
- CS  in  1  SPI chip select, active low, asynchronous to clk
- SCLK  in  1  SPI clock, mode 0 (MCU samples rising, block drives after falling), asynchronous
- MISO  out  1  serial data
- MISO_OE  out  1  output enable for MISO pad, 1 while frame selected
- BUSY  out  1  1 in SHIFT state
- DONE  out  1  one-cycle pulse: frame ended with exactly FRAME_BITS rising edges
- ABORT  out  1  one-cycle pulse: frame ended with count ≠ FRAME_BITS

## Operation
- SCLK and CS each pass through SYNC_STAGES flops, plus one history flop for edge detection. Synchroniser reset value: SCLK=0, CS=1.
- Shadow register: LOAD=1 with clk_en=1 → shadow ← data_in in any state. A LOAD during SHIFT never alters the frame in flight.
- States:
  - WAIT_HIGH (reset state): stay until synced CS=1, then → IDLE. This prevents a CS held low through reset from starting a partial frame.
  - IDLE: synced CS falling edge → shift_reg ← shadow, bit_cnt ← 0, MISO ← shadow[FRAME_BITS-1], → SHIFT.
  - SHIFT, synced SCLK rising: bit_cnt ← bit_cnt+1, saturating at FRAME_BITS+1.
  - SHIFT, synced SCLK falling with bit_cnt ≥ 1: shift_reg ← shift_reg<<1 (zero fill), MISO ← new MSB. Falling edges before the first rising edge are ignored.
  - SHIFT, synced CS rising: if bit_cnt==FRAME_BITS pulse DONE, else pulse ABORT; → IDLE. MISO ← 0.
- After FRAME_BITS bits, further SCLK edges shift out zeros; at CS rise the frame still ends in ABORT.
- Simultaneous CS rising and SCLK edge in the same cycle: the CS edge wins and the SCLK edge is discarded.
- MISO_OE = synced CS==0 and state==SHIFT.
- Shadow is never cleared by transmission. A second frame with no intervening LOAD resends the same data.

## Timing
- Reset values: MISO=0, MISO_OE=0, BUSY=0, DONE=0, ABORT=0, shadow=0, shift_reg=0, bit_cnt=0, state=WAIT_HIGH.
- Pin CS fall → MISO valid with bit FRAME_BITS-1: SYNC_STAGES+2 clk cycles.
- Pin SCLK fall → next MISO bit: SYNC_STAGES+2 clk cycles.
- Interface constraints, with clk_en=1 throughout:
  - SCLK high and low phases each ≥ SYNC_STAGES+3 clk cycles, i.e. SCLK ≤ 4.8 MHz at 48 MHz clk with 2 stages.
  - CS fall to first SCLK rise ≥ SYNC_STAGES+3 cycles.
  - Last SCLK fall to CS rise ≥ 2 cycles.
- DONE/ABORT assert SYNC_STAGES+2 cycles after pin CS rise and last exactly one clk_en cycle.
- LOAD → shadow visible next cycle. A LOAD in the same cycle as the synced CS fall is not seen: the old shadow is sent and the new value is held for the next frame.
- Reset asserted mid-frame: frame dropped, no DONE/ABORT, MISO=0 next cycle, → WAIT_HIGH.

## Test plan
- Load {64'h80000000000000F1, 48'h1, 48'h2, 32'h3, 64'h4, 16'h1, 8'h0, 32'h5, 32'h6, 32'h7, 32'h8}, CS low, 408 SCLK at 4 MHz, sample on rising → captured 408 bits equal the loaded vector, DONE one pulse, ABORT 0, BUSY high for the whole frame.
- Two back-to-back frames, LOAD 408'hA5…A5 only before the first → both frames read A5…A5. Then LOAD all-ones during frame 2 → frame 2 unchanged, frame 3 reads all-ones.
- CS rise after 200 SCLK → ABORT pulse, no DONE, MISO=0, state IDLE. Next full frame starts again from bit 407.
- 410 SCLK in one frame → bits 408..409 read 0, ABORT pulse at CS rise.
- Hold CS low across rst, release rst, clock 16 SCLK → MISO_OE=0, no shifting. Raise then lower CS → normal frame. Separately, rst at bit 100 → no DONE/ABORT, MISO=0.
- clk_en toggling 1/0 each cycle with SCLK scaled ×2 → frame identical to the first test; DONE pulse lasts one enabled cycle.
